// File: rtl/abcd_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// abcd_pkg: shared frame geometry, FSM encodings and position-to-output mapping
// Revision: 1.0
//------------------------------------------------------------------------------
package abcd_pkg;

    localparam int FRAME_BITS = 4;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    // Frame vector layout is {a,b,c,d}.
    typedef logic [FRAME_BITS-1:0] frame_t;

    // pos[p] holds the p-th serial bit received; returns {a,b,c,d}.
    function automatic frame_t map_frame(input frame_t pos, input bit msb_first);
        frame_t f;
        if (msb_first) begin
            f = {pos[0], pos[1], pos[2], pos[3]};
        end else begin
            f = pos;
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/abcd_idle_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// abcd_idle_timer: counts idle cycles and pulses expire on the last allowed one
// Revision: 1.0
//------------------------------------------------------------------------------
module abcd_idle_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] r_idle_cnt;
            logic             w_at_last;

            assign w_at_last = (r_idle_cnt == LAST);

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_idle_cnt <= '0;
                end else if (enable) begin
                    r_idle_cnt <= w_at_last ? '0 : r_idle_cnt + 1'b1;
                end
            end

            // Reset outranks an expiry in the same cycle.
            assign expire = enable & ~clear & ~rst & w_at_last;
        end else begin : g_no_timer
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clear, enable};
            assign expire   = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/abcd_deserializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// abcd_deserializer: 4-bit serial frame to held a,b,c,d with valid/ready output
// Revision: 1.0
//------------------------------------------------------------------------------
module abcd_deserializer
    import abcd_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    input  logic sin_valid,
    output logic sin_ready,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic out_valid,
    input  logic out_ready,
    output logic frame_err
);

    logic [0:0]           r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    frame_t               r_shift;
    frame_t               r_frame;
    logic                 r_out_valid;

    logic   w_in_collect;
    logic   w_acc;
    logic   w_last_bit;
    logic   w_timer_en;
    logic   w_expire;
    frame_t w_shift_ins;

    assign w_in_collect = (r_state == ST_COLLECT);
    assign sin_ready    = w_in_collect | out_ready;
    assign w_acc        = sin_valid & sin_ready;
    assign w_last_bit   = (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    assign w_timer_en   = w_in_collect & (r_bit_cnt != '0) & ~w_acc;

    // In HOLD the shift register and bit counter are already zero, so the same
    // insert path serves a bit accepted during the handoff cycle.
    always_comb begin
        w_shift_ins            = r_shift;
        w_shift_ins[r_bit_cnt] = sin;
    end

    abcd_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (~w_timer_en),
        .enable (w_timer_en),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_in_collect) begin
            if (w_acc && w_last_bit) begin
                r_frame     <= map_frame(w_shift_ins, MSB_FIRST);
                r_out_valid <= 1'b1;
                r_state     <= ST_HOLD;
                r_bit_cnt   <= '0;
                r_shift     <= '0;
            end else if (w_acc) begin
                r_shift   <= w_shift_ins;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_expire) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_COLLECT;
            if (w_acc) begin
                r_shift   <= w_shift_ins;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign {a, b, c, d} = r_frame;
    assign out_valid    = r_out_valid;
    assign frame_err    = w_expire;

endmodule
`default_nettype wire
